// File: rtl/riscv_regfile_pkg.sv
// Shared configuration for the RV32I integer register file.
// Define RISCV_RF_BYPASS_EN to enable same-cycle write-through forwarding on the read ports.
`ifndef XLEN
`define XLEN 32
`endif

package riscv_regfile_pkg;
    localparam int XLEN         = `XLEN;
    localparam int REG_NUM      = 32;
    localparam int REG_ADDR_BIT = $clog2(REG_NUM);
endpackage

// File: rtl/riscv_regfile_rdport.sv
// One combinational register-file read port: x0 reads zero, with optional write-through
// forwarding when RISCV_RF_BYPASS_EN is defined.
module riscv_regfile_rdport
    import riscv_regfile_pkg::*;
(
    input  logic [REG_ADDR_BIT-1:0] i_rs_addr,
    input  logic [XLEN-1:0]         i_rf [REG_NUM],
`ifdef RISCV_RF_BYPASS_EN
    input  logic                    i_rstn,
    input  logic                    i_rd_we,
    input  logic [REG_ADDR_BIT-1:0] i_rd_addr,
    input  logic [XLEN-1:0]         i_rd_data,
`endif
    output logic [XLEN-1:0]         o_rs_data
);

    always_comb begin
        o_rs_data = '0;
        if (i_rs_addr != '0) begin
            o_rs_data = i_rf[i_rs_addr];
`ifdef RISCV_RF_BYPASS_EN
            // Forwarding is held off during reset so a reset edge never exposes the dropped write.
            if (i_rstn && i_rd_we && (i_rs_addr == i_rd_addr)) begin
                o_rs_data = i_rd_data;
            end
`endif
        end
    end

endmodule

// File: rtl/riscv_regfile.sv
// 32 x XLEN integer register file: two async read ports, one sync write port, x0 hardwired zero.
// Define RISCV_RF_BYPASS_EN to forward the write data to matching read ports in the same cycle.
module riscv_regfile
    import riscv_regfile_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic [REG_ADDR_BIT-1:0] i_rf_rs1_addr,
    input  logic [REG_ADDR_BIT-1:0] i_rf_rs2_addr,
    output logic [XLEN-1:0]         o_rf_rs1_data,
    output logic [XLEN-1:0]         o_rf_rs2_data,
    input  logic                    i_rf_rd_we,
    input  logic [REG_ADDR_BIT-1:0] i_rf_rd_addr,
    input  logic [XLEN-1:0]         i_rf_rd_data
);

    logic [XLEN-1:0] regs_q [1:REG_NUM-1];
    logic [XLEN-1:0] regs_d [1:REG_NUM-1];
    logic [XLEN-1:0] rf_view [REG_NUM];

    always_comb begin
        regs_d = regs_q;
        if (i_rf_rd_we && (i_rf_rd_addr != '0)) begin
            regs_d[i_rf_rd_addr] = i_rf_rd_data;
        end
    end

    // Reset wins over a coincident write; the write is simply lost.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            for (int i = 1; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rf_view[0] = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            rf_view[i] = regs_q[i];
        end
    end

    riscv_regfile_rdport u_rdport_rs1 (
        .i_rs_addr (i_rf_rs1_addr),
        .i_rf      (rf_view),
`ifdef RISCV_RF_BYPASS_EN
        .i_rstn    (i_rstn),
        .i_rd_we   (i_rf_rd_we),
        .i_rd_addr (i_rf_rd_addr),
        .i_rd_data (i_rf_rd_data),
`endif
        .o_rs_data (o_rf_rs1_data)
    );

    riscv_regfile_rdport u_rdport_rs2 (
        .i_rs_addr (i_rf_rs2_addr),
        .i_rf      (rf_view),
`ifdef RISCV_RF_BYPASS_EN
        .i_rstn    (i_rstn),
        .i_rd_we   (i_rf_rd_we),
        .i_rd_addr (i_rf_rd_addr),
        .i_rd_data (i_rf_rd_data),
`endif
        .o_rs_data (o_rf_rs2_data)
    );

endmodule

// File: doc/riscv_regfile.md
Name: riscv_regfile

Overview:
- 32 x `XLEN integer register file for the RV32I core: two asynchronous read ports, one synchronous write port.
- Sits directly upstream of the ALU operand riscv_mux instances. o_rf_rs1_data and o_rf_rs2_data become slices of their i_mux_concat_data.
- Writeback mux output drives the write port.
- x0 is hardwired to zero.

Parameters:
- REG_NUM, 32, number of architectural registers (x0..x31).
- REG_ADDR_BIT, $clog2(REG_NUM) = 5, register address width.

Ports:
- i_clk  input  1  core clock; all state updates on rising edge.
- i_rstn  input  1  synchronous active-low reset, sampled on rising edge of i_clk.
- i_rf_rs1_addr  input  REG_ADDR_BIT  read port 1 address.
- i_rf_rs2_addr  input  REG_ADDR_BIT  read port 2 address.
- o_rf_rs1_data  output  `XLEN  read port 1 data.
- o_rf_rs2_data  output  `XLEN  read port 2 data.
- i_rf_rd_we  input  1  write enable.
- i_rf_rd_addr  input  REG_ADDR_BIT  write address.
- i_rf_rd_data  input  `XLEN  write data.

Behaviour:
- Storage: registers x1..x31, each `XLEN bits. x0 has no storage.
- Reset:
  - On a rising edge with i_rstn=0, x1..x31 all become 0. Reset takes priority over a simultaneous write, and the write is dropped.
  - Outputs follow storage, so both read ports return 0 for every address after reset.
  - Reset asserted mid-stream: contents are cleared on that edge regardless of in-flight writes. There is no partial state.
- Write:
  - On a rising edge with i_rstn=1, i_rf_rd_we=1 and i_rf_rd_addr!=0, x[i_rf_rd_addr] <= i_rf_rd_data.
  - Writes to x0 are silently discarded.
  - i_rf_rd_we=0 leaves all contents unchanged. No other register is ever disturbed.
- Read:
  - Combinational, zero latency: o_rf_rsN_data = (addr==0) ? 0 : x[addr].
  - A write becomes visible on the read ports in the cycle after its edge.
- Same address on rs1 and rs2: both ports return identical data.
- Same-cycle read/write conflict (read addr == i_rf_rd_addr with we=1): the result depends on the optional feature below.
- Default for that conflict: old value is read.
- Data is taken verbatim. There is no width conversion or sign handling.
- X on addresses when we=0 must not corrupt state.

Optional Feature:
- Macro: RISCV_RF_BYPASS_EN.
- Defined:
  - Write-through forwarding on both read ports. If i_rf_rd_we=1, i_rf_rd_addr!=0 and rsN_addr==i_rf_rd_addr, then o_rf_rsN_data = i_rf_rd_data in the same cycle.
  - x0 still reads 0 even when being written.
  - Bypass is suppressed while i_rstn=0.
- Undefined: no bypass. A same-cycle read returns the pre-write stored value.

Decomposition:
- Shared package/header riscv_configs.v:
  - `XLEN (32).
  - REG_NUM and REG_ADDR_BIT constants.
  - The RISCV_RF_BYPASS_EN macro switch.
- One natural sub-module, riscv_regfile_rdport: a single read port carrying the x0 zero check and optional bypass compare. It is instantiated twice, once for rs1 and once for rs2.

Test Plan:
- Reset: hold i_rstn=0 for 2 cycles while writing x5=32'hDEADBEEF, then read rs1=5, rs2=31. Both outputs must be 32'h0.
- Write/read sweep: write x[k]=32'h1000_0000+k for k=1..31 on consecutive cycles, then read all pairs (k, 32-k). Every output must equal its written value, and x0 must read 0.
- x0 protection: write x0=32'hFFFF_FFFF with we=1, then read rs1=0 and rs2=0. Both must be 32'h0 in the same cycle and on the next cycle.
- we gating: write x7=32'hA5A5A5A5, then drive addr=7, data=32'h12345678, we=0 for 3 cycles. x7 must still read 32'hA5A5A5A5.
- Same-cycle conflict: x3 holds 32'h11111111. Write x3=32'h22222222 while rs1=rs2=3.
  - With RISCV_RF_BYPASS_EN defined, both outputs must be 32'h22222222 that cycle.
  - Without it, both must be 32'h11111111 that cycle, then 32'h22222222 on the next cycle.
- Random regression: 100 vectors of $urandom addr/data/we against a reference array model, with an op-mux feed check.
  - Compare both read ports every cycle.
  - Include a mid-run reset pulse, after which every read must be 0.
